// File: rtl/counter_ctrl.sv
// Command-driven control stage for a 4-bit up-counter: prescaled run, step, load.
// Define COUNTER_CTRL_AUTO_RELOAD_EN to reload the counter from reload_val on wrap.
module counter_ctrl #(
  parameter int DATA_W     = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [DATA_W-1:0]     cmd_data,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [DATA_W-1:0]     cnt_in,
  output logic                  EN,
  output logic                  LOAD,
  output logic [DATA_W-1:0]     load_out,
  output logic                  wrap_pulse,
  output logic                  busy,
  output logic [1:0]            state_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_LOAD = 2'b11
  } state_t;

  localparam logic [1:0] OP_STOP = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  state_t                state;
  state_t                ret_state;
  logic [PRESCALE_W-1:0] psc;
  logic                  acc;

  assign acc       = cmd_valid && cmd_ready;
  assign state_out = state;

`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
  logic [DATA_W-1:0] reload_val;
  logic              ar_load;
  logic [DATA_W-1:0] cnt_nxt;

  // Counter value once the current EN/LOAD strobe has taken effect.
  always_comb begin
    cnt_nxt = cnt_in;
    if (EN)
      cnt_nxt = cnt_in + 1'b1;
    else if (LOAD)
      cnt_nxt = load_out;
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      ret_state  <= S_IDLE;
      psc        <= '0;
      EN         <= 1'b0;
      LOAD       <= 1'b0;
      load_out   <= '0;
      wrap_pulse <= 1'b0;
      busy       <= 1'b0;
      cmd_ready  <= 1'b1;
`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
      reload_val <= '0;
      ar_load    <= 1'b0;
`endif
    end else begin
      EN        <= 1'b0;
      LOAD      <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
      ar_load    <= 1'b0;
      wrap_pulse <= (EN | ar_load) & (&cnt_in);
`else
      wrap_pulse <= EN & (&cnt_in);
`endif
      if (state == S_STEP || state == S_LOAD) begin
        state <= ret_state;
        psc   <= '0;
      end else if (acc) begin
        // An accepted command always wins over a due tick.
        psc <= '0;
        unique case (cmd_op)
          OP_STOP: state <= S_IDLE;
          OP_RUN:  state <= S_RUN;
          OP_STEP: begin
            state     <= S_STEP;
            ret_state <= state;
            EN        <= 1'b1;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
          end
          OP_LOAD: begin
            state     <= S_LOAD;
            ret_state <= state;
            LOAD      <= 1'b1;
            load_out  <= cmd_data;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
            reload_val <= cmd_data;
`endif
          end
        endcase
      end else if (state == S_RUN) begin
        if (psc >= prescale) begin
          psc <= '0;
`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
          if (&cnt_nxt) begin
            LOAD     <= 1'b1;
            load_out <= reload_val;
            ar_load  <= 1'b1;
          end else begin
            EN <= 1'b1;
          end
`else
          EN <= 1'b1;
`endif
        end else begin
          psc <= psc + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl with a behavioural 4-bit counter on cnt_in.
// Outputs are sampled 1 time unit after each rising edge.
module tb_counter_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [7:0] prescale;
  logic [3:0] cnt;
  logic       EN;
  logic       LOAD;
  logic [3:0] load_out;
  logic       wrap_pulse;
  logic       busy;
  logic [1:0] state_out;

  int n_tests = 0;
  int n_fail  = 0;

  counter_ctrl #(.DATA_W(4), .PRESCALE_W(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .prescale  (prescale),
    .cnt_in    (cnt),
    .EN        (EN),
    .LOAD      (LOAD),
    .load_out  (load_out),
    .wrap_pulse(wrap_pulse),
    .busy      (busy),
    .state_out (state_out)
  );

  always #5 CLK = ~CLK;

  // Downstream counter model
  always_ff @(posedge CLK) begin
    if (RST)
      cnt <= 4'h0;
    else if (LOAD)
      cnt <= load_out;
    else if (EN)
      cnt <= cnt + 4'h1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    cyc();
    cmd_valid = 1'b0;
  endtask

  always @(negedge CLK)
    if (!RST)
      chk("en_load_excl", {31'd0, EN & LOAD}, 32'd0);

  initial begin
    RST       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 4'h0;
    prescale  = 8'd0;

    // Reset values
    repeat (3) cyc();
    chk("rst_en", EN, 0);
    chk("rst_load", LOAD, 0);
    chk("rst_load_out", load_out, 0);
    chk("rst_state", state_out, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_wrap", wrap_pulse, 0);
    RST = 1'b0;
    cyc();

    // Prescale 3: EN at accept+4, +8; STOP at +10 kills +12
    prescale = 8'd3;
    send(2'b01, 4'h0);
    chk("run_state", state_out, 2'b01);
    chk("run_ready", cmd_ready, 1);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk("ps3_gap1", EN, 0);
    end
    cyc();
    chk("ps3_en1", EN, 1);
    for (int i = 5; i <= 7; i++) begin
      cyc();
      chk("ps3_gap2", EN, 0);
    end
    cyc();
    chk("ps3_en2", EN, 1);
    cyc();
    chk("ps3_gap3", EN, 0);
    send(2'b00, 4'h0);
    chk("stop_state", state_out, 2'b00);
    chk("stop_en", EN, 0);
    cyc();
    cyc();
    chk("stop_no_en", EN, 0);
    chk("ps3_cnt", cnt, 4'h2);

    // Reset while running
    prescale = 8'd0;
    send(2'b01, 4'h0);
    cyc();
    chk("run0_en", EN, 1);
    RST = 1'b1;
    cyc();
    chk("mrst_state", state_out, 0);
    chk("mrst_en", EN, 0);
    chk("mrst_load", LOAD, 0);
    chk("mrst_ready", cmd_ready, 1);
    chk("mrst_busy", busy, 0);
    chk("mrst_wrap", wrap_pulse, 0);
    RST = 1'b0;
    cyc();
    chk("mrst_hold", state_out, 0);

    // LOAD then STEP from IDLE
    send(2'b11, 4'hA);
    chk("ld_load", LOAD, 1);
    chk("ld_val", load_out, 4'hA);
    chk("ld_ready", cmd_ready, 0);
    chk("ld_busy", busy, 1);
    chk("ld_state", state_out, 2'b11);
    chk("ld_en", EN, 0);
    cyc();
    chk("ld_done_load", LOAD, 0);
    chk("ld_done_state", state_out, 0);
    chk("ld_hold_val", load_out, 4'hA);
    chk("ld_cnt", cnt, 4'hA);
    send(2'b10, 4'h0);
    chk("st_en", EN, 1);
    chk("st_state", state_out, 2'b10);
    chk("st_busy", busy, 1);
    chk("st_ready", cmd_ready, 0);
    cyc();
    chk("st_done_en", EN, 0);
    chk("st_done_state", state_out, 0);
    chk("st_cnt", cnt, 4'hB);

    // Wrap with prescale 0 from E
    send(2'b11, 4'hE);
    cyc();
    chk("w_cnt_e", cnt, 4'hE);
    send(2'b01, 4'h0);
    cyc();
    chk("w_en1", EN, 1);
    chk("w_cnt1", cnt, 4'hE);
    cyc();
    chk("w_cnt2", cnt, 4'hF);
    chk("w_wrap2", wrap_pulse, 0);
`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
    chk("w_ar_load", LOAD, 1);
    chk("w_ar_en", EN, 0);
`else
    chk("w_en2", EN, 1);
`endif
    cyc();
    chk("w_wrap3", wrap_pulse, 1);
`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
    chk("w_cnt3", cnt, 4'hE);
`else
    chk("w_cnt3", cnt, 4'h0);
`endif
    cyc();
    chk("w_wrap4", wrap_pulse, 0);
    send(2'b00, 4'h0);
    chk("w_stop", state_out, 0);

    // Step on tick-due cycle, prescale 5
    prescale = 8'd5;
    send(2'b01, 4'h0);
    for (int i = 1; i <= 5; i++) begin
      cyc();
      chk("ps5_gap1", EN, 0);
    end
    cyc();
    chk("ps5_en1", EN, 1);
    for (int i = 7; i <= 11; i++) begin
      cyc();
      chk("ps5_gap2", EN, 0);
    end
    send(2'b10, 4'h0);
    chk("ps5_step_en", EN, 1);
    chk("ps5_step_state", state_out, 2'b10);
    cyc();
    chk("ps5_ret_state", state_out, 2'b01);
    chk("ps5_ret_en", EN, 0);
    for (int i = 1; i <= 5; i++) begin
      cyc();
      chk("ps5_gap3", EN, 0);
    end
    cyc();
    chk("ps5_en2", EN, 1);
    send(2'b00, 4'h0);
    chk("ps5_stop", state_out, 0);

    // Full sequence from 3 with prescale 0
    prescale = 8'd0;
    send(2'b11, 4'h3);
    cyc();
    chk("seq_cnt0", cnt, 4'h3);
    send(2'b01, 4'h0);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk("seq_en", EN, 1);
      chk("seq_cnt", cnt, 32'(k + 2));
      chk("seq_wrap", wrap_pulse, 0);
    end
    cyc();
    chk("seq_cnt_f", cnt, 4'hF);
`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
    chk("seq_ar_load", LOAD, 1);
    chk("seq_ar_en", EN, 0);
    chk("seq_ar_val", load_out, 4'h3);
`else
    chk("seq_en_f", EN, 1);
`endif
    cyc();
    chk("seq_wrap_hi", wrap_pulse, 1);
`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
    chk("seq_cnt_rl", cnt, 4'h3);
`else
    chk("seq_cnt_0", cnt, 4'h0);
`endif
    cyc();
    chk("seq_wrap_lo", wrap_pulse, 0);
    send(2'b00, 4'h0);
    chk("seq_stop", state_out, 0);
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
- Control stage directly upstream of the 4-bit up-counter; drives the counter's EN, LOAD and load_in pins from a command interface.
- Provides a programmable prescaler (free-run mode), single-step and load commands, and a clean one-cycle wrap pulse derived from the counter's c_out feedback.
- The counter's own overflow flag is sticky and is never cleared, so this block's wrap pulse is the per-event indication used by downstream logic.

Parameters:
- DATA_W, 4, counter width; matches counter c_out/load_in.
- PRESCALE_W, 8, width of prescale input and internal prescaler.

Ports:
- CLK  input  1  single clock.
- RST  input  1  reset; synchronous, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command this cycle.
- cmd_op  input  2  00 STOP, 01 RUN, 10 STEP, 11 LOAD.
- cmd_data  input  DATA_W  load value; used only with LOAD.
- prescale  input  PRESCALE_W  free-run tick period minus one; sampled live.
- cnt_in  input  DATA_W  counter c_out feedback.
- EN  output  1  counter enable; one-cycle pulses.
- LOAD  output  1  counter load strobe; one-cycle pulse.
- load_out  output  DATA_W  drives counter load_in.
- wrap_pulse  output  1  one cycle; counter wrapped from all-ones.
- busy  output  1  high in STEP and LOADING.
- state_out  output  2  00 IDLE, 01 RUN, 10 STEP, 11 LOADING.

Behaviour:
- All outputs registered. Reset values: state IDLE, EN 0, LOAD 0, load_out 0, wrap_pulse 0, busy 0, cmd_ready 1, prescaler 0, return-state IDLE.
- RST mid-operation takes priority over everything; pending step/load is discarded.
- Handshake: a command is accepted when cmd_valid && cmd_ready. cmd_ready = 1 in IDLE/RUN and 0 in STEP/LOADING. One command per cycle. Unknown ops do not exist, because the 2-bit op space is fully decoded.
- IDLE: EN is 0. RUN goes to RUN; STEP goes to STEP with return-state IDLE; LOAD goes to LOADING with return-state IDLE; STOP has no effect.
- RUN:
  - The prescaler counts up each cycle.
  - When prescaler >= prescale, EN = 1 the next cycle and the prescaler clears.
  - Entering RUN clears the prescaler. If the command is accepted in cycle N, the first EN is in cycle N+1+prescale.
  - prescale=0 gives EN every cycle.
  - If prescale is lowered below the current count, the next cycle ticks.
- RUN command handling:
  - STOP goes to IDLE; EN is 0 from the next cycle.
  - STEP goes to STEP with return-state RUN.
  - LOAD goes to LOADING with return-state RUN.
  - RUN restarts the prescaler.
  - A command accepted in the same cycle a tick is due wins; that tick is dropped and the prescaler clears.
- STEP: lasts exactly 1 cycle; EN = 1 for that cycle, then return-state with the prescaler cleared.
- LOADING: lasts exactly 1 cycle; LOAD = 1 and load_out = cmd_data captured at acceptance, then return-state with the prescaler cleared. load_out holds its last value afterwards.
- EN and LOAD are never high in the same cycle.
- Wrap: wrap_pulse = 1 in the cycle after any cycle with EN=1 and cnt_in = all-ones. cnt_in is the pre-increment value during the EN cycle. No pulse for a LOAD cycle.
- busy = 1 in STEP/LOADING.

Optional Feature:
- Macro: COUNTER_CTRL_AUTO_RELOAD_EN.
- With it defined:
  - A reload_val register (reset 0) is updated with cmd_data on every accepted LOAD.
  - In RUN, a due tick with cnt_in = all-ones asserts LOAD (load_out = reload_val) instead of EN.
  - wrap_pulse still fires the following cycle.
  - Step ticks are unaffected.
- Without it: no reload_val register; the counter wraps naturally to 0.

Test Plan:
1. RST held 3 cycles then released → EN=0, LOAD=0, load_out=0, state_out=00, cmd_ready=1. Assert RST while in RUN → next edge returns to all reset values.
2. prescale=3, RUN accepted at cycle 10 → EN pulses at cycles 14, 18, 22. STOP accepted at 20 → no EN at 22.
3. From IDLE: LOAD cmd_data=4'hA → LOAD=1 and load_out=A for one cycle, cmd_ready=0 that cycle, then IDLE. Next, STEP → one EN pulse, then back to IDLE.
4. prescale=0, RUN with counter at 4'hE → EN every cycle. wrap_pulse is high exactly one cycle after the EN cycle where cnt_in=F; counter reads 0.
5. RUN with prescale=5 and a STEP accepted on the tick-due cycle → a single EN from STEP, the tick is dropped, the prescaler restarts, and the next EN comes 6 cycles after the return to RUN.
6. (AUTO_RELOAD) LOAD 4'h3, then RUN with prescale=0 → counter sequence 3..F, then LOAD pulse returns it to 3, with wrap_pulse once per cycle of the sequence. Without the macro, the counter sequence goes F → 0.
